elevator_motion_ctrl: RTL and testbench

- Consumer and driver of the 4-bit up/down period timer.
- Accepts floor requests over a valid/ready handshake.
- Steers the timer's direction and reset to measure floor-to-floor travel time (counting up) and door-open dwell time (counting down).
- Tracks the current floor and reports motion and door status to the elevator top level.

---
 rtl/elevator_motion_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_elevator_motion_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_motion_ctrl.sv
// rtl/elevator_motion_ctrl.sv - elevator motion/door sequencer driving a 4-bit up/down period timer
// Optional emergency stop: define ELEVATOR_ESTOP_EN to add the estop input and HALT state.
module elevator_motion_ctrl #(
    parameter int NUM_FLOORS   = 8,
    parameter int FLOOR_W      = 3,
    parameter int TRAVEL_TICKS = 10,
    parameter int DOOR_TICKS   = 6
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ELEVATOR_ESTOP_EN
    input  logic               estop,
`endif
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    input  logic [3:0]         period,
    output logic               timer_rst,
    output logic               timer_dir,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               moving,
    output logic               going_up,
    output logic               door_open,
    output logic               arrived,
    output logic               req_err
);

`ifdef ELEVATOR_ESTOP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ARM_MOVE, S_MOVE, S_ARM_DOOR, S_DOOR, S_HALT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ARM_MOVE, S_MOVE, S_ARM_DOOR, S_DOOR
    } state_t;
`endif

    // Arrival is one floor's worth of up-counting; the door dwell counts down
    // from 0 (wrapping to 15) until it has taken DOOR_TICKS steps.
    localparam logic [3:0] TRAVEL_CMP = 4'(TRAVEL_TICKS);
    localparam logic [3:0] DOOR_CMP   = 4'(16 - DOOR_TICKS);

    state_t               state_q, state_d;
    logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
    logic [FLOOR_W-1:0]   target_q, target_d;
    logic                 going_up_q, going_up_d;
    logic                 arrived_q, arrived_d;
    logic                 req_err_q, req_err_d;

    logic [FLOOR_W-1:0]   floor_step;
    logic [31:0]          req_floor_ext;
    logic                 req_oob;
    logic                 handshake;

    assign floor_step    = going_up_q ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1);
    assign req_floor_ext = 32'(req_floor);
    assign req_oob       = req_floor_ext >= 32'(NUM_FLOORS);
    assign handshake     = req_valid && req_ready;

    // State and datapath registers; rst aborts any trip without an arrival pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_floor_q <= '0;
            target_q    <= '0;
            going_up_q  <= 1'b1;
            arrived_q   <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            target_q    <= target_d;
            going_up_q  <= going_up_d;
            arrived_q   <= arrived_d;
            req_err_q   <= req_err_d;
        end
    end

    // Next-state and datapath updates, including floor stepping on each travel period.
    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        target_d    = target_q;
        going_up_d  = going_up_q;
        arrived_d   = 1'b0;
        req_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    if (req_oob) begin
                        req_err_d = 1'b1;
                    end else if (req_floor == cur_floor_q) begin
                        state_d   = S_ARM_DOOR;
                        arrived_d = 1'b1;
                    end else begin
                        target_d   = req_floor;
                        going_up_d = req_floor > cur_floor_q;
                        state_d    = S_ARM_MOVE;
                    end
                end
            end
            S_ARM_MOVE: state_d = S_MOVE;
            S_MOVE: begin
                if (period == TRAVEL_CMP) begin
                    cur_floor_d = floor_step;
                    if (floor_step == target_q) begin
                        state_d   = S_ARM_DOOR;
                        arrived_d = 1'b1;
                    end else begin
                        state_d = S_ARM_MOVE;
                    end
                end
            end
            S_ARM_DOOR: state_d = S_DOOR;
            S_DOOR: begin
                if (period == DOOR_CMP) begin
                    state_d = S_IDLE;
                end
            end
`ifdef ELEVATOR_ESTOP_EN
            S_HALT: begin
                if (!estop) begin
                    state_d  = S_IDLE;
                    target_d = cur_floor_q;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef ELEVATOR_ESTOP_EN
        // Emergency stop freezes the floor and drops any in-flight event.
        if (estop) begin
            state_d     = S_HALT;
            cur_floor_d = cur_floor_q;
            target_d    = target_q;
            going_up_d  = going_up_q;
            arrived_d   = 1'b0;
            req_err_d   = 1'b0;
        end
`endif
    end

    // Moore outputs: timer control and status derived from the current state.
    always_comb begin
        timer_rst = 1'b1;
        timer_dir = 1'b1;
        req_ready = 1'b0;
        moving    = 1'b0;
        door_open = 1'b0;
        case (state_q)
            S_IDLE: begin
`ifdef ELEVATOR_ESTOP_EN
                req_ready = !rst && !estop;
`else
                req_ready = !rst;
`endif
            end
            S_ARM_MOVE: moving = 1'b1;
            S_MOVE: begin
                timer_rst = 1'b0;
                moving    = 1'b1;
            end
            S_ARM_DOOR: begin
                timer_dir = 1'b0;
                door_open = 1'b1;
            end
            S_DOOR: begin
                timer_rst = 1'b0;
                timer_dir = 1'b0;
                door_open = 1'b1;
            end
`ifdef ELEVATOR_ESTOP_EN
            S_HALT: begin
                timer_dir = 1'b0;
                door_open = 1'b1;
            end
`endif
            default: begin
                timer_rst = 1'b1;
            end
        endcase
    end

    assign cur_floor = cur_floor_q;
    assign going_up  = going_up_q;
    assign arrived   = arrived_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// tb/tb_elevator_motion_ctrl.sv - scoreboard bench for elevator_motion_ctrl with a behavioural period timer
module tb_elevator_motion_ctrl;
    localparam int FW = 4;
    localparam int K_FLR = 0, K_ARR = 1, K_ERR = 2, K_DOOR = 3, K_RDY = 4;

    typedef struct {
        int kind;
        int val;
        int off;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [FW-1:0] req_floor = '0;
    logic [3:0]    period = 4'd0;
    logic          req_ready, timer_rst, timer_dir, moving, going_up, door_open, arrived, req_err;
    logic [FW-1:0] cur_floor;
`ifdef ELEVATOR_ESTOP_EN
    logic          estop = 1'b0;
`endif

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  hs = 0;
    logic mon_en = 1'b0;
    logic [FW-1:0] prev_floor = '0;
    logic prev_door = 1'b0;
    logic prev_ready = 1'b0;
    int  door_cnt = 0;

    elevator_motion_ctrl #(.NUM_FLOORS(8), .FLOOR_W(FW), .TRAVEL_TICKS(10), .DOOR_TICKS(6)) dut (
        .clk(clk), .rst(rst),
`ifdef ELEVATOR_ESTOP_EN
        .estop(estop),
`endif
        .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready),
        .period(period), .timer_rst(timer_rst), .timer_dir(timer_dir),
        .cur_floor(cur_floor), .moving(moving), .going_up(going_up),
        .door_open(door_open), .arrived(arrived), .req_err(req_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (timer_rst) period <= 4'd0;
        else if (timer_dir) period <= period + 4'd1;
        else period <= period - 4'd1;
    end

    function automatic string kname(int k);
        case (k)
            K_FLR:   return "floor";
            K_ARR:   return "arrived";
            K_ERR:   return "req_err";
            K_DOOR:  return "door_len";
            default: return "ready";
        endcase
    endfunction

    task automatic chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(int kind, int val, int off);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.off  = off;
        exp_q.push_back(e);
    endtask

    task automatic got(int kind, int val);
        ev_t e;
        int off;
        off = cyc - hs;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got val=%0d off=%0d, required no event", kname(kind), val, off);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.off != off) begin
                n_bad++;
                $display("FAIL event_%s: got %s val=%0d off=%0d, required %s val=%0d off=%0d",
                         kname(e.kind), kname(kind), val, off, kname(e.kind), e.val, e.off);
            end
        end
    endtask

    // Monitor: turn DUT output activity into events and compare against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cur_floor != prev_floor) got(K_FLR, int'({going_up, cur_floor}));
            if (arrived) got(K_ARR, int'(cur_floor));
            if (req_err) got(K_ERR, int'(cur_floor));
            if (!door_open && prev_door) got(K_DOOR, door_cnt);
            if (req_ready && !prev_ready) got(K_RDY, 1);
            if (moving) chk("timer_dir_move", int'(timer_dir), 1);
            if (door_open) chk("timer_dir_door", int'(timer_dir), 0);
        end
        door_cnt   <= door_open ? door_cnt + 1 : 0;
        prev_floor <= cur_floor;
        prev_door  <= door_open;
        prev_ready <= req_ready;
    end

    task automatic send(int f, bit hold);
        req_floor = FW'(f);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        hs = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && req_ready) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending events, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cur_floor", int'(cur_floor), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_timer_rst", int'(timer_rst), 1);
        chk("rst_arrived", int'(arrived), 0);
        chk("rst_req_err", int'(req_err), 0);
        chk("rst_going_up", int'(going_up), 1);
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Floor 0 -> 3: steps every 12 cycles, 8-cycle door
        send(3, 1'b0);
        expect_ev(K_FLR, 16 + 1, 12);
        expect_ev(K_FLR, 16 + 2, 24);
        expect_ev(K_FLR, 16 + 3, 36);
        expect_ev(K_ARR, 3, 36);
        expect_ev(K_DOOR, 8, 44);
        expect_ev(K_RDY, 1, 44);
        wait_drain(200);

        // Floor 3 -> 1 going down
        send(1, 1'b0);
        expect_ev(K_FLR, 2, 12);
        expect_ev(K_FLR, 1, 24);
        expect_ev(K_ARR, 1, 24);
        expect_ev(K_DOOR, 8, 32);
        expect_ev(K_RDY, 1, 32);
        wait_drain(200);

        // Request the current floor: door cycle only
        send(1, 1'b0);
        expect_ev(K_ARR, 1, 0);
        expect_ev(K_DOOR, 8, 8);
        expect_ev(K_RDY, 1, 8);
        wait_drain(100);

        // Out-of-range request is dropped with an error pulse
        send(9, 1'b0);
        expect_ev(K_ERR, 1, 0);
        @(negedge clk);
        chk("err_ready", int'(req_ready), 1);
        chk("err_floor", int'(cur_floor), 1);
        chk("err_moving", int'(moving), 0);
        wait_drain(100);

        // Floor 1 -> 7 with req_valid held, reset between floors 4 and 5
        send(7, 1'b1);
        expect_ev(K_FLR, 16 + 2, 12);
        expect_ev(K_FLR, 16 + 3, 24);
        expect_ev(K_FLR, 16 + 4, 36);
        expect_ev(K_FLR, 16 + 0, 42);
        expect_ev(K_RDY, 1, 42);
        for (int i = 1; i <= 41; i++) begin
            @(posedge clk);
            #1;
            if (i == 5 || i == 30) chk("busy_ready", int'(req_ready), 0);
        end
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", int'(req_ready), 1);
        chk("abort_floor", int'(cur_floor), 0);
        chk("abort_timer_rst", int'(timer_rst), 1);
        chk("abort_arrived", int'(arrived), 0);
        wait_drain(100);

`ifdef ELEVATOR_ESTOP_EN
        // Emergency stop while travelling from floor 2 toward 3
        send(3, 1'b0);
        expect_ev(K_FLR, 16 + 1, 12);
        expect_ev(K_FLR, 16 + 2, 24);
        expect_ev(K_DOOR, 3, 34);
        expect_ev(K_RDY, 1, 34);
        repeat (30) @(posedge clk);
        #1 estop = 1'b1;
        @(posedge clk);
        #1;
        chk("halt_moving", int'(moving), 0);
        chk("halt_door", int'(door_open), 1);
        chk("halt_floor", int'(cur_floor), 2);
        chk("halt_timer_rst", int'(timer_rst), 1);
        chk("halt_ready", int'(req_ready), 0);
        repeat (2) @(posedge clk);
        #1 estop = 1'b0;
        wait_drain(100);
        chk("estop_idle_ready", int'(req_ready), 1);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
